// File: rtl/lift_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lift_timer_arbiter
// Brief    : One prescaled tick and one countdown timer shared by NREQ lift
//            requesters; grants one interval at a time and pulses done on
//            expiry. Define ROUND_ROBIN_EN for rotating priority, otherwise
//            the lowest requesting index wins.
// Revision : 1.0
// ============================================================================
module lift_timer_arbiter #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10,
  parameter int NREQ    = 3,
  parameter int TW      = 8
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*TW-1:0] dur,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               tick,
  output logic [TW-1:0]      remain
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   win_q, win_d, pick;
  logic [PW-1:0]   pre_q, pre_d;
  logic            tick_q, tick_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   remain_q, remain_d, dur_w;
  logic [NREQ-1:0] grant_q, grant_d, done_q, done_d;
  logic [NREQ-1:0] mask_q, mask_d, cand, win_oh_q, win_oh_d;
  logic            abort;

  assign cand     = req & ~mask_q;
  assign dur_w    = dur[int'(win_q)*TW +: TW];
  assign abort    = ((state_q == S_LOAD) || (state_q == S_COUNT)) && !req[win_q];
  assign win_oh_q = NREQ'(1) << win_q;

`ifdef ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Descending scan so the nearest index at/after ptr is the last assignment.
  always_comb begin
    pick = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (cand[(int'(ptr_q) + k) % NREQ]) pick = IW'((int'(ptr_q) + k) % NREQ);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == S_DONE) || abort)
      ptr_d = (win_q == IW'(NREQ-1)) ? '0 : win_q + IW'(1);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    pick = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (cand[i]) pick = IW'(i);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    remain_d = remain_q;
    mask_d   = '0;
    case (state_q)
      S_IDLE: begin
        remain_d = '0;
        if (|cand) begin
          win_d   = pick;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d  = S_IDLE;
          remain_d = '0;
        end else begin
          remain_d = dur_w;
          state_d  = (dur_w == '0) ? S_DONE : S_COUNT;
        end
      end
      S_COUNT: begin
        // A dropped request beats an expiry landing on the same tick.
        if (abort) begin
          state_d  = S_IDLE;
          remain_d = '0;
        end else if (tick_q) begin
          if (remain_q != '0) remain_d = remain_q - TW'(1);
          if (remain_q <= TW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        mask_d  = win_oh_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    win_oh_d = NREQ'(1) << win_d;
    busy_d   = (state_d != S_IDLE);
    grant_d  = busy_d ? win_oh_d : '0;
    done_d   = (state_d == S_DONE) ? win_oh_d : '0;
    tick_d   = (pre_q == PW'(DIV-1));
    // Restarting the prescaler on LOAD makes every granted interval exact.
    if ((state_d == S_LOAD) || (pre_q == PW'(DIV-1))) pre_d = '0;
    else                                              pre_d = pre_q + PW'(1);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      remain_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      remain_q <= remain_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      mask_q   <= mask_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign tick   = tick_q;
  assign remain = remain_q;

endmodule
`default_nettype wire

// File: tb/tb_lift_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lift_timer_arbiter
// Brief    : Randomised requesters drive lift_timer_arbiter; a transaction
//            model predicts each grant and a monitor checks every cycle.
// Revision : 1.0
// ============================================================================
module tb_lift_timer_arbiter;

  localparam int CLK_HZ  = 40;
  localparam int TICK_HZ = 10;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int NREQ    = 3;
  localparam int TW      = 8;

  logic               CLK = 1'b0;
  logic               reset = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*TW-1:0] dur = '0;
  logic [NREQ-1:0]    grant, done;
  logic               busy, tick;
  logic [TW-1:0]      remain;

  lift_timer_arbiter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NREQ(NREQ), .TW(TW)) dut (
    .CLK(CLK), .reset(reset), .req(req), .dur(dur),
    .grant(grant), .done(done), .busy(busy), .tick(tick), .remain(remain)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int w;   // winner index
    int g;   // first cycle grant is visible (LOAD)
    int d;   // interval sampled in LOAD
    bit ab;  // interval is aborted
    int e;   // last cycle grant is visible
  } txn_t;

  txn_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   tref = 0;

  // Requester/arbiter model state
  logic [NREQ-1:0] pend;
  int m_ptr, free_at, mask_at, mask_w, load_at, load_w;
  int cur_w, cur_g, cur_d, end_at, abort_at, rel_at, rel_w;
  bit cur_ab, quiet;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int arb(input logic [NREQ-1:0] cand, input int p);
`ifdef ROUND_ROBIN_EN
    for (int k = 0; k < NREQ; k++) if (cand[(p + k) % NREQ]) return (p + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++) if (cand[k] && p >= 0) return k;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    sbq.delete();
    cur_w = -1; load_at = -1; abort_at = -1; rel_at = -1; mask_at = -1;
    m_ptr = 0; free_at = cyc; tref = cyc;
  endtask

  // One cycle of requester behaviour plus the arbitration prediction.
  task automatic act(input bit directed);
    int c, w, d, e;
    bit ab, locked;
    logic [NREQ-1:0] cand, msk;
    txn_t tx;
    c = cyc;
    if (cur_w >= 0 && c > end_at) cur_w = -1;
    for (int i = 0; i < NREQ; i++)
      dur[i*TW +: TW] = directed ? TW'(1) : TW'($urandom_range(0, 4));
    if (rel_at == c) begin
      if (quiet || (!directed && $urandom_range(0, 1) == 0)) pend[rel_w] = 1'b0;
      rel_at = -1;
    end
    for (int i = 0; i < NREQ; i++) begin
      locked = (i == cur_w) || (load_at >= 0 && i == load_w);
      if (quiet) begin
        if (!locked) pend[i] = 1'b0;
      end else if (!directed) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 5) == 0) pend[i] = 1'b1;
        end else if (!locked && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
      end
    end
    if (load_at == c) begin
      d  = int'(dur[load_w*TW +: TW]);
      ab = !directed && !quiet && ($urandom_range(0, 3) == 0);
      if (ab) e = ($urandom_range(0, 1) == 1) ? c + DIV*d : c + int'($urandom_range(0, DIV*d));
      else    e = c + 1 + DIV*d;
      tx.w = load_w; tx.g = c; tx.d = d; tx.ab = ab; tx.e = e;
      sbq.push_back(tx);
      cur_w = load_w; cur_g = c; cur_d = d; cur_ab = ab; end_at = e; free_at = e + 1;
      abort_at = ab ? e : -1;
      mask_at  = ab ? -1 : e + 1;
      mask_w   = load_w;
      rel_at   = ab ? -1 : e + 1;
      rel_w    = load_w;
      m_ptr    = (load_w + 1) % NREQ;
      load_at  = -1;
    end
    if (abort_at == c) begin
      pend[cur_w] = 1'b0;
      abort_at = -1;
    end
    req = pend;
    if (load_at < 0 && c >= free_at) begin
      msk  = (mask_at == c) ? (NREQ'(1) << mask_w) : '0;
      cand = req & ~msk;
      w    = arb(cand, m_ptr);
      if (w >= 0) begin
        load_at = c + 1;
        load_w  = w;
        free_at = 32'h7fff_ffff;
      end
    end
  endtask

  task automatic step(input bit directed);
    @(posedge CLK);
    #1;
    act(directed);
  endtask

  initial begin : monitor
    txn_t cur;
    bit cur_v;
    logic [NREQ-1:0] prev_g;
    int t;
    longint eg, ed, er;
    cur_v = 1'b0;
    prev_g = '0;
    forever begin
      @(negedge CLK);
      t = cyc;
      if (!reset) begin
        cur_v = 1'b0;
        prev_g = '0;
        check("reset_grant", grant, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_tick", tick, 0);
        check("reset_remain", remain, 0);
      end else begin
        if (cur_v && t > cur.e) cur_v = 1'b0;
        check("tick", tick, (t > tref && ((t - tref) % DIV) == 0) ? 1 : 0);
        if (grant != '0 && prev_g == '0) begin
          if (sbq.size() == 0) begin
            check("unexpected_grant", grant, 0);
          end else begin
            cur = sbq.pop_front();
            cur_v = 1'b1;
            check("grant_cycle", t, cur.g);
            tref = cur.g;
          end
        end else if (!cur_v && sbq.size() > 0 && sbq[0].g < t) begin
          check("grant_missing", grant, 1 << sbq[0].w);
          void'(sbq.pop_front());
        end
        eg = cur_v ? (1 << cur.w) : 0;
        ed = (cur_v && !cur.ab && t == cur.e) ? eg : 0;
        er = (!cur_v || t == cur.g) ? 0 : cur.d - (t - cur.g - 1) / DIV;
        check("grant", grant, eg);
        check("done", done, ed);
        check("remain", remain, er);
        check("busy", busy, cur_v ? 1 : 0);
        prev_g = grant;
      end
    end
  end

  initial begin : main
    bit found, idle;
    pend = '0; quiet = 1'b0;
    m_ptr = 0; free_at = 0; mask_at = -1; mask_w = 0; load_at = -1; load_w = 0;
    cur_w = -1; cur_g = 0; cur_d = 0; cur_ab = 1'b0; end_at = 0;
    abort_at = -1; rel_at = -1; rel_w = 0;
    repeat (3) @(posedge CLK);
    @(posedge CLK);
    #1;
    reset = 1'b1;
    model_reset();
    pend = '1;
    act(1'b1);
    // All three requesting with unit intervals and holding through done.
    repeat (40) step(1'b1);
    repeat (1500) step(1'b0);

    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      step(1'b0);
      if (cur_w >= 0 && !cur_ab && cur_d >= 2 && cyc == cur_g + 3) found = 1'b1;
    end
    check("reset_window", found, 1);
    if (found) begin
      #2;
      reset = 1'b0;
      sbq.delete();
      #1;
      check("async_reset_grant", grant, 0);
      check("async_reset_done", done, 0);
      check("async_reset_busy", busy, 0);
      check("async_reset_tick", tick, 0);
      check("async_reset_remain", remain, 0);
      pend = NREQ'(1);
      req = pend;
      repeat (2) @(posedge CLK);
      #1;
      reset = 1'b1;
      model_reset();
      act(1'b0);
    end
    repeat (1500) step(1'b0);

    quiet = 1'b1;
    idle = 1'b0;
    for (int k = 0; k < 300 && !idle; k++) begin
      step(1'b0);
      idle = (cur_w < 0) && (load_at < 0) && (pend == '0);
    end
    check("drain_idle", idle, 1);
    repeat (4) step(1'b0);
    check("scoreboard_empty", sbq.size(), 0);
    check("final_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
